// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared constants and state encoding for the 3-tap median stream
package median_pkg;

  localparam int WIDTH_DEFAULT = 4;

  // Window fill level; encoding fixed at 0/1/2 for register-map compatibility.
  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/median3.sv
// rtl/median3.sv - purely combinational unsigned median of three WIDTH-bit values
module median3
  import median_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] median
);

  always_comb begin
    median = b;
    if (a >= b) begin
      if (b >= c)      median = b;
      else if (a >= c) median = c;
      else             median = a;
    end else begin
      if (a >= c)      median = a;
      else if (b >= c) median = c;
      else             median = b;
    end
  end

endmodule

// File: rtl/median3_stream_ctrl.sv
// rtl/median3_stream_ctrl.sv - 3-tap sliding-window median filter with a valid/ready output register
module median3_stream_ctrl
  import median_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_median,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             warm
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w0_q, w0_d, w1_q, w1_d;
  logic [WIDTH-1:0] median_q, median_d, med_w;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept, consume;

  median3 #(.WIDTH(WIDTH)) u_median3 (
    .a      (w0_q),
    .b      (w1_q),
    .c      (in_data),
    .median (med_w)
  );

  assign in_ready   = !valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign consume    = valid_q && out_ready;
  assign out_valid  = valid_q;
  assign out_median = median_q;
  assign out_count  = count_q;
  assign warm       = (state_q == STREAM);

  always_comb begin
    state_d  = state_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    median_d = median_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (consume) begin
      valid_d = 1'b0;
      count_d = count_q + CNT_W'(1);
    end

    // Flush drops a coincident sample but leaves any pending result intact.
    if (flush) begin
      state_d = FILL0;
      w0_d    = '0;
      w1_d    = '0;
    end else if (accept) begin
      case (state_q)
        FILL0: begin
          w1_d    = in_data;
          state_d = FILL1;
        end
        FILL1: begin
          w0_d    = w1_q;
          w1_d    = in_data;
          state_d = STREAM;
        end
        STREAM: begin
          median_d = med_w;
          valid_d  = 1'b1;
          w0_d     = w1_q;
          w1_d     = in_data;
        end
        default: state_d = FILL0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL0;
      w0_q     <= '0;
      w1_q     <= '0;
      median_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      median_q <= median_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_median3_stream_ctrl.sv
// tb/tb_median3_stream_ctrl.sv - self-checking bench for the 3-tap median stream controller
module tb_median3_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, warm;
  logic [3:0]  out_median;
  logic [15:0] out_count;

  logic        rst2, flush2, in_valid2, out_ready2;
  logic [3:0]  in_data2;
  logic        in_ready2, out_valid2, warm2;
  logic [3:0]  out_median2;
  logic [1:0]  out_count2;

  logic [3:0]  ma, mb, mc, mm;

  int n_pass = 0;
  int n_total = 0;

  int win[$];
  bit m_valid;
  int m_med, m_cnt;

  always #5 clk = ~clk;

  median3_stream_ctrl #(.WIDTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_median(out_median), .out_ready(out_ready),
    .out_count(out_count), .warm(warm)
  );

  median3_stream_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .flush(flush2), .out_valid(out_valid2), .out_median(out_median2), .out_ready(out_ready2),
    .out_count(out_count2), .warm(warm2)
  );

  median3 #(.WIDTH(4)) u_med (.a(ma), .b(mb), .c(mc), .median(mm));

  function automatic int ref_median(int a, int b, int c);
    int q[$];
    q = {a, b, c};
    q.sort();
    return q[1];
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(bit r, bit f, bit v, int d, bit o);
    rst = r; flush = f; in_valid = v; in_data = 4'(d); out_ready = o;
  endtask

  // One clock of the main DUT, checked against the queue-based reference model.
  task automatic cycle();
    bit acc, cons;
    #1;
    chk("model_in_ready", int'(in_ready), int'(!m_valid || out_ready));
    @(posedge clk);
    if (rst) begin
      win.delete(); m_valid = 0; m_med = 0; m_cnt = 0;
    end else begin
      acc  = in_valid && (!m_valid || out_ready);
      cons = m_valid && out_ready;
      if (cons) begin m_valid = 0; m_cnt = (m_cnt + 1) % 65536; end
      if (flush) win.delete();
      else if (acc) begin
        if (win.size() == 2) begin
          m_med = ref_median(win[0], win[1], int'(in_data));
          m_valid = 1;
        end
        win.push_back(int'(in_data));
        if (win.size() > 2) void'(win.pop_front());
      end
    end
    #1;
    chk("model_out_valid", int'(out_valid), int'(m_valid));
    chk("model_out_median", int'(out_median), m_med);
    chk("model_out_count", int'(out_count), m_cnt);
    chk("model_warm", int'(warm), int'(win.size() == 2));
  endtask

  typedef struct {
    bit r, v;
    int d;
    bit e_rdy, e_valid;
    int e_med, e_cnt;
    bit e_warm;
  } vec_t;

  initial begin
    vec_t tbl[8];
    tbl[0] = '{1, 0, 0,  1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 5,  1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 1,  1, 0, 0, 0, 1};
    tbl[3] = '{0, 1, 9,  1, 1, 5, 0, 1};
    tbl[4] = '{0, 1, 3,  1, 1, 3, 1, 1};
    tbl[5] = '{0, 1, 3,  1, 1, 3, 2, 1};
    tbl[6] = '{0, 1, 12, 1, 1, 3, 3, 1};
    tbl[7] = '{0, 0, 0,  1, 0, 3, 4, 1};

    rst2 = 1; flush2 = 0; in_valid2 = 0; in_data2 = 0; out_ready2 = 1;
    ma = 0; mb = 0; mc = 0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r, 0, tbl[i].v, tbl[i].d, 1);
      #1 chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
      cycle();
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_out_median", i), int'(out_median), tbl[i].e_med);
      chk($sformatf("tbl%0d_out_count", i), int'(out_count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_warm", i), int'(warm), int'(tbl[i].e_warm));
    end

    // Backpressure: window holds 3,12; result 4 stalls while 6 waits at the input.
    drive(0, 0, 1, 4, 0); cycle();
    chk("bp_load_median", int'(out_median), 4);
    drive(0, 0, 1, 6, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_median_stable", int'(out_median), 4);
    end
    drive(0, 0, 1, 6, 1); cycle();
    chk("bp_release_median", int'(out_median), 6);
    chk("bp_release_count", int'(out_count), 5);
    drive(0, 0, 0, 0, 1); cycle();

    // Flush after 7,7; a sample presented with flush is dropped.
    drive(0, 1, 0, 0, 1); cycle();
    drive(0, 0, 1, 7, 1); cycle();
    drive(0, 0, 1, 7, 1); cycle();
    drive(0, 1, 1, 9, 1); cycle();
    chk("flush_warm_cleared", int'(warm), 0);
    drive(0, 0, 1, 2, 1); cycle();
    drive(0, 0, 1, 15, 1); cycle();
    chk("flush_no_early_result", int'(out_valid), 0);
    drive(0, 0, 1, 0, 1); cycle();
    chk("flush_first_valid", int'(out_valid), 1);
    chk("flush_first_median", int'(out_median), 2);

    // Reset mid-stream with a stalled result pending.
    drive(0, 0, 1, 5, 0); cycle();
    chk("rst_pre_valid", int'(out_valid), 1);
    drive(1, 0, 1, 5, 0); cycle();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(out_count), 0);
    chk("rst_warm", int'(warm), 0);
    drive(0, 0, 1, 15, 1); cycle();
    drive(0, 0, 1, 0, 1); cycle();
    drive(0, 0, 1, 8, 1); cycle();
    chk("rst_after_median", int'(out_median), 8);

    for (int i = 0; i < 2000; i++) begin
      drive(0, ($urandom_range(15) == 0), ($urandom_range(3) != 0),
            int'($urandom_range(15)), ($urandom_range(3) != 0));
      cycle();
    end

    // Counter wrap on the narrow build.
    @(posedge clk); #1 rst2 = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid2 = (i < 7); in_data2 = 4'(i + 1);
      @(posedge clk); #1;
      if (i >= 3) chk($sformatf("cnt2_step%0d", i), int'(out_count2), (i - 2) % 4);
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++) begin
          ma = 4'(a); mb = 4'(b); mc = 4'(c);
          #1 chk($sformatf("median3_%0d_%0d_%0d", a, b, c), int'(mm), ref_median(a, b, c));
        end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
